// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT butterfly stages.
//
// Contents:
//   clog2()       - ceiling log2, used to size beat counters and pointers
//   sdf_state_t   - run/drain state of a butterfly stage
//   cplx_lane_t   - one complex lane at the default stage output width
package fft_pkg;

   // Ceiling log2 of n (n >= 2). Elaboration-time only.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned v = n - 1; v != 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

   // Stage sequencing: normal input-driven operation, or self-timed drain of
   // the last frame's difference results.
   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } sdf_state_t;

   // Complex lane at the default geometry (9-bit input grown by one bit).
   localparam int LANE_W = 10;

   typedef struct packed {
      logic signed [LANE_W-1:0] re;
      logic signed [LANE_W-1:0] im;
   } cplx_lane_t;

endpackage

// File: rtl/bf_delay_line.sv
// Feedback storage for one component (re or im) of an SDF butterfly stage.
// A circular buffer of DEPTH beats: the oldest entry is always on rdata_o,
// and each enabled cycle overwrites it with wdata_i and steps the pointer, so
// a word written on one enabled cycle reappears exactly DEPTH enables later.
//
// Ports:
//   clk, rstn  - clock, asynchronous active-low reset (pointer only)
//   en_i       - advance: write wdata_i and step the pointer
//   wdata_i    - LANES x DW word to store
//   rdata_o    - LANES x DW word stored DEPTH enables ago
module bf_delay_line
   import fft_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int LANES = 16,
   parameter int DW    = 10
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     en_i,
   input  logic [LANES-1:0][DW-1:0] wdata_i,
   output logic [LANES-1:0][DW-1:0] rdata_o
);

   localparam int PW = clog2(DEPTH);

   logic [PW-1:0]            ptr_q;
   logic [LANES-1:0][DW-1:0] mem_q [DEPTH];

   // DEPTH is a power of two, so the pointer wraps on its own.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr_q <= '0;
      end else if (en_i) begin
         ptr_q <= ptr_q + PW'(1);
      end
   end

   // Storage is deliberately left unreset; the stage never exposes an entry
   // that has not been rewritten since reset.
   always_ff @(posedge clk) begin
      if (en_i) begin
         mem_q[ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[ptr_q];

endmodule

// File: rtl/bf_sdf_stage.sv
// Radix-2 single-delay-feedback butterfly stage, LANES complex samples/beat.
// A frame is 2*DEPTH beats. First half: inputs are parked in the delay line
// while the previous frame's differences stream out. Second half: parked
// value a meets new value b, a+b is output and a-b is parked for later.
//
// Ports:
//   clk, rstn          - clock, asynchronous active-low reset
//   in_valid/in_ready  - input beat handshake (in_ready low only in drain)
//   din_re, din_im     - LANES x WIDTH signed input lanes
//   out_valid, out_sof - output qualifier, first add beat of a frame
//   dout_re, dout_im   - LANES x O_WIDTH signed output lanes
//   busy               - delay line holds undelivered data
module bf_sdf_stage
   import fft_pkg::*;
#(
   parameter int   WIDTH   = 9,
   parameter int   LANES   = 16,
   parameter int   DEPTH   = 16,
   parameter int   SCALE   = 0,
   parameter int   TRIV_J  = 0,
   localparam int  O_WIDTH = WIDTH + 1 - SCALE
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES-1:0][WIDTH-1:0]   din_re,
   input  logic [LANES-1:0][WIDTH-1:0]   din_im,
   output logic                          out_valid,
   output logic                          out_sof,
   output logic [LANES-1:0][O_WIDTH-1:0] dout_re,
   output logic [LANES-1:0][O_WIDTH-1:0] dout_im,
   output logic                          busy
);

   localparam int AW = WIDTH + 1;
   localparam int CW = clog2(2 * DEPTH);

   localparam logic [CW-1:0] CNT_AEND = CW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_J    = CW'(DEPTH + DEPTH / 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(2 * DEPTH - 1);

   sdf_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pending_q, pending_d;
   logic          out_valid_q, out_sof_q;

   logic [LANES-1:0][O_WIDTH-1:0] dout_re_q, dout_im_q;
   logic [LANES-1:0][O_WIDTH-1:0] dout_re_d, dout_im_d;
   logic [LANES-1:0][AW-1:0]      dl_rd_re, dl_rd_im, dl_wr_re, dl_wr_im;

   logic drain, advance, phase_b, triv, emit;

   assign drain    = (state_q == ST_DRAIN);
   assign in_ready = !drain;
   assign advance  = (in_valid && in_ready) || drain;
   assign phase_b  = (cnt_q >= CNT_HALF);
   assign triv     = (TRIV_J != 0) && (cnt_q >= CNT_J);
   // Second half always produces a sum; first half produces a parked
   // difference only when the previous frame left some behind.
   assign emit     = phase_b || pending_q;
   assign busy     = pending_q || (cnt_q != '0);

   // Drain starts only when a frame boundary is reached with differences
   // outstanding and nothing arriving; it runs exactly DEPTH beats and then
   // returns to the frame start rather than continuing into the second half.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      case (state_q)
         ST_RUN: begin
            if (advance) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  pending_d = 1'b1;
               end else if (cnt_q == CNT_AEND) begin
                  pending_d = 1'b0;
               end
            end else if (pending_q && (cnt_q == '0)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_AEND) begin
               cnt_d     = '0;
               pending_d = 1'b0;
               state_d   = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
      end
   end

   // Per-lane datapath, all at WIDTH+1 bits so sums and differences of two
   // WIDTH-bit values (including a -j rotated one) never wrap.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic signed [AW-1:0] a_re, a_im, bx_re, bx_im, b_re, b_im;
      logic signed [AW-1:0] sum_re, sum_im, dif_re, dif_im, res_re, res_im;

      assign a_re   = dl_rd_re[i];
      assign a_im   = dl_rd_im[i];
      assign bx_re  = {din_re[i][WIDTH-1], din_re[i]};
      assign bx_im  = {din_im[i][WIDTH-1], din_im[i]};
      assign b_re   = triv ? bx_im  : bx_re;
      assign b_im   = triv ? -bx_re : bx_im;
      assign sum_re = a_re + b_re;
      assign sum_im = a_im + b_im;
      assign dif_re = a_re - b_re;
      assign dif_im = a_im - b_im;

      // Drain flushes zeros so stale data never survives into a later frame.
      assign dl_wr_re[i] = phase_b ? dif_re : (drain ? '0 : bx_re);
      assign dl_wr_im[i] = phase_b ? dif_im : (drain ? '0 : bx_im);
      assign res_re      = phase_b ? sum_re : a_re;
      assign res_im      = phase_b ? sum_im : a_im;

      if (SCALE != 0) begin : g_scale
         // Round half up, halve, keep WIDTH bits. The extra bit keeps +1 on
         // the largest difference from wrapping before the shift.
         logic signed [AW:0] rnd_re, rnd_im;
         logic               lane_unused;
         assign rnd_re       = {res_re[AW-1], res_re} + (AW + 1)'(1);
         assign rnd_im       = {res_im[AW-1], res_im} + (AW + 1)'(1);
         assign dout_re_d[i] = rnd_re[WIDTH:1];
         assign dout_im_d[i] = rnd_im[WIDTH:1];
         assign lane_unused  = ^{rnd_re[AW], rnd_re[0], rnd_im[AW], rnd_im[0]};
      end else begin : g_full
         assign dout_re_d[i] = res_re;
         assign dout_im_d[i] = res_im;
      end
   end

   bf_delay_line #(.DEPTH(DEPTH), .LANES(LANES), .DW(AW)) u_dl_re (
      .clk     (clk),
      .rstn    (rstn),
      .en_i    (advance),
      .wdata_i (dl_wr_re),
      .rdata_o (dl_rd_re)
   );

   bf_delay_line #(.DEPTH(DEPTH), .LANES(LANES), .DW(AW)) u_dl_im (
      .clk     (clk),
      .rstn    (rstn),
      .en_i    (advance),
      .wdata_i (dl_wr_im),
      .rdata_o (dl_rd_im)
   );

   // Output register: data only moves on a beat that is actually delivered,
   // so unwritten delay-line contents never show up on dout.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         dout_re_q   <= '0;
         dout_im_q   <= '0;
      end else if (advance) begin
         out_valid_q <= emit;
         out_sof_q   <= (cnt_q == CNT_HALF);
         if (emit) begin
            dout_re_q <= dout_re_d;
            dout_im_q <= dout_im_d;
         end
      end else begin
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sof   = out_sof_q;
   assign dout_re   = dout_re_q;
   assign dout_im   = dout_im_q;

endmodule
